// File: rtl/truth_table_decoder.sv
// Collects the four rows of a 2-input truth table in any order and presents the
// decoded minterm mask, its popcount and a single-term flag. Conflicting rows are rejected.
module truth_table_decoder #(
  parameter int ALLOW_DUP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       a,
  input  logic       b,
  input  logic       s,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] minterms,
  output logic [2:0] ones_count,
  output logic       single_term,
  output logic       error
);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] DONE    = 2'd1;
  localparam logic [1:0] ERR     = 2'd2;

  logic [1:0] state;
  logic [3:0] seen;
  logic [3:0] value;
  logic [1:0] idx;
  logic [3:0] seen_nxt;
  logic       dup_bad;
  logic [2:0] pop;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  assign idx      = {a, b};
  assign seen_nxt = seen | (4'b0001 << idx);
  // A revisited row is fatal if it disagrees, or if repeats are not tolerated at all.
  assign dup_bad  = (value[idx] != s) || (ALLOW_DUP == 0);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state <= COLLECT;
      seen  <= 4'b0000;
      value <= 4'b0000;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            if (seen[idx]) begin
              if (dup_bad) state <= ERR;
            end else begin
              seen       <= seen_nxt;
              value[idx] <= s;
              if (&seen_nxt) state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= COLLECT;
            seen  <= 4'b0000;
            value <= 4'b0000;
          end
        end
        ERR:     state <= ERR;
        default: state <= COLLECT;
      endcase
    end
  end

  assign pop         = popcount4(value);
  assign in_ready    = (state == COLLECT);
  assign out_valid   = (state == DONE);
  assign error       = (state == ERR);
  assign minterms    = out_valid ? value : 4'b0000;
  assign ones_count  = out_valid ? pop : 3'd0;
  assign single_term = out_valid && (pop == 3'd1);

endmodule

// File: tb/tb_truth_table_decoder.sv
// Bench for truth_table_decoder: two instances (duplicates tolerated / rejected) share
// the stimulus and are compared against a row-table reference model.
module tb_truth_table_decoder;

  logic clk = 1'b0;
  logic rst_n, clear, in_valid, a, b, s, out_ready;
  logic       ir1, ov1, er1, st1, ir0, ov0, er0, st0;
  logic [3:0] mt1, mt0;
  logic [2:0] oc1, oc0;
  logic [10:0] obs1, obs0;

  int passed = 0;
  int total  = 0;

  // Reference model: per instance, the s value known for each row (-1 = not yet given).
  int rv [2][4];
  bit merr [2];
  bit mdone [2];

  always #5 clk = ~clk;

  truth_table_decoder #(.ALLOW_DUP(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .s(s), .out_valid(ov1), .out_ready(out_ready), .minterms(mt1),
    .ones_count(oc1), .single_term(st1), .error(er1)
  );

  truth_table_decoder #(.ALLOW_DUP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir0),
    .a(a), .b(b), .s(s), .out_valid(ov0), .out_ready(out_ready), .minterms(mt0),
    .ones_count(oc0), .single_term(st0), .error(er0)
  );

  assign obs1 = {ir1, ov1, er1, mt1, oc1, st1};
  assign obs0 = {ir0, ov0, er0, mt0, oc0, st0};

  task automatic model_clear(input int k);
    for (int i = 0; i < 4; i++) rv[k][i] = -1;
    merr[k]  = 1'b0;
    mdone[k] = 1'b0;
  endtask

  task automatic model_update(input int k, input bit allow);
    int idx;
    bit full;
    if (!rst_n || clear) begin
      model_clear(k);
    end else if (mdone[k]) begin
      if (out_ready) model_clear(k);
    end else if (!merr[k] && in_valid) begin
      idx = int'(a) * 2 + int'(b);
      if (rv[k][idx] == -1) begin
        rv[k][idx] = int'(s);
        full = 1'b1;
        for (int i = 0; i < 4; i++) if (rv[k][i] == -1) full = 1'b0;
        mdone[k] = full;
      end else if (rv[k][idx] != int'(s) || !allow) begin
        merr[k] = 1'b1;
      end
    end
  endtask

  // Expected {in_ready, out_valid, error, minterms, ones_count, single_term}.
  function automatic logic [10:0] exp_vec(input int k);
    int mt;
    int cnt;
    mt  = 0;
    cnt = 0;
    if (mdone[k]) begin
      for (int i = 0; i < 4; i++) if (rv[k][i] == 1) begin mt += (1 << i); cnt++; end
      return {1'b0, 1'b1, 1'b0, mt[3:0], cnt[2:0], (cnt == 1)};
    end
    if (merr[k]) return 11'b001_0000_0000;
    return 11'b100_0000_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    model_update(0, 1'b0);
    model_update(1, 1'b1);
    #1;
  endtask

  task automatic send_row(input logic ra, input logic rb, input logic rs);
    in_valid = 1'b1; a = ra; b = rb; s = rs;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step(); step();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
    total++; if (obs1 !== 11'b100_0000_0000) $display("FAIL reset_dup1 got=%b exp=%b", obs1, 11'b100_0000_0000); else passed++;
    total++; if (obs0 !== 11'b100_0000_0000) $display("FAIL reset_dup0 got=%b exp=%b", obs0, 11'b100_0000_0000); else passed++;
  endtask

  task automatic test_in_order();
    send_row(0, 0, 0); send_row(0, 1, 1); send_row(1, 0, 0);
    total++; if (ov1 !== 1'b0) $display("FAIL in_order_early_valid got=%b exp=0", ov1); else passed++;
    send_row(1, 1, 0);
    total++; if (ov1 !== 1'b1) $display("FAIL in_order_valid got=%b exp=1", ov1); else passed++;
    total++; if (mt1 !== 4'b0010) $display("FAIL in_order_minterms got=%b exp=0010", mt1); else passed++;
    total++; if (oc1 !== 3'd1) $display("FAIL in_order_count got=%0d exp=1", oc1); else passed++;
    total++; if (st1 !== 1'b1) $display("FAIL in_order_single got=%b exp=1", st1); else passed++;
    total++; if (obs0 !== exp_vec(0)) $display("FAIL in_order_dup0 got=%b exp=%b", obs0, exp_vec(0)); else passed++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    total++; if (obs1 !== exp_vec(1)) $display("FAIL in_order_handshake got=%b exp=%b", obs1, exp_vec(1)); else passed++;
  endtask

  task automatic test_out_of_order_hold();
    send_row(1, 1, 1); send_row(0, 1, 0); send_row(0, 0, 1); send_row(1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      total++; if (mt1 !== 4'b1101 || oc1 !== 3'd3 || st1 !== 1'b0 || ov1 !== 1'b1 || ir1 !== 1'b0)
        $display("FAIL hold_cycle%0d got=%b exp=%b", i, obs1, 11'b010_1101_0110); else passed++;
      step();
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    total++; if (ir1 !== 1'b1 || mt1 !== 4'b0000 || ov1 !== 1'b0)
      $display("FAIL hold_release got=%b exp=%b", obs1, 11'b100_0000_0000); else passed++;
  endtask

  task automatic test_dup_allowed();
    send_row(0, 0, 1); send_row(0, 0, 1);
    total++; if (er1 !== 1'b0) $display("FAIL dup_ok_error got=%b exp=0", er1); else passed++;
    total++; if (er0 !== 1'b1) $display("FAIL dup_rejected_error got=%b exp=1", er0); else passed++;
    send_row(0, 1, 1); send_row(1, 0, 1); send_row(1, 1, 1);
    total++; if (mt1 !== 4'b1111 || oc1 !== 3'd4 || er1 !== 1'b0)
      $display("FAIL dup_table got=%b exp=%b", obs1, 11'b010_1111_1000); else passed++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    send_row(0, 1, 1); send_row(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      total++; if (er1 !== 1'b1 || ir1 !== 1'b0)
        $display("FAIL conflict_err%0d got=%b exp=%b", i, obs1, 11'b001_0000_0000); else passed++;
      send_row(1, 1, 1);
    end
    clear = 1'b1; step(); clear = 1'b0;
    total++; if (er1 !== 1'b0 || ir1 !== 1'b1 || ir0 !== 1'b1)
      $display("FAIL conflict_clear got=%b exp=%b", obs1, 11'b100_0000_0000); else passed++;
  endtask

  task automatic test_dup_rejected();
    send_row(1, 0, 0);
    total++; if (er0 !== 1'b0) $display("FAIL nodup_first got=%b exp=0", er0); else passed++;
    send_row(1, 0, 0);
    total++; if (er0 !== 1'b1) $display("FAIL nodup_second got=%b exp=1", er0); else passed++;
    total++; if (er1 !== 1'b0) $display("FAIL nodup_dup1 got=%b exp=0", er1); else passed++;
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic test_clear_wins();
    send_row(0, 0, 1); send_row(0, 1, 1); send_row(1, 0, 0);
    clear = 1'b1; send_row(1, 1, 0); clear = 1'b0;
    total++; if (ov1 !== 1'b0 || ir1 !== 1'b1) $display("FAIL clear_wins got=%b exp=%b", obs1, 11'b100_0000_0000); else passed++;
    send_row(1, 1, 0); send_row(1, 0, 1); send_row(0, 1, 0);
    total++; if (ov1 !== 1'b0) $display("FAIL clear_no_carry got=%b exp=0", ov1); else passed++;
    send_row(0, 0, 0);
    total++; if (mt1 !== 4'b0100 || ov1 !== 1'b1) $display("FAIL clear_next_table got=%b exp=0100", mt1); else passed++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_row(0, 0, 0); send_row(1, 1, 0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    total++; if (obs1 !== 11'b100_0000_0000) $display("FAIL reset_mid got=%b exp=%b", obs1, 11'b100_0000_0000); else passed++;
    send_row(0, 0, 1); send_row(0, 1, 0); send_row(1, 0, 0);
    total++; if (ov1 !== 1'b0) $display("FAIL reset_mid_carry got=%b exp=0", ov1); else passed++;
    send_row(1, 1, 1);
    total++; if (mt1 !== 4'b1001 || oc1 !== 3'd2 || st1 !== 1'b0)
      $display("FAIL reset_mid_table got=%b exp=%b", obs1, 11'b010_1001_0100); else passed++;
    out_ready = 1'b1; rst_n = 1'b0; step(); rst_n = 1'b1; out_ready = 1'b0;
    total++; if (obs1 !== 11'b100_0000_0000) $display("FAIL reset_done got=%b exp=%b", obs1, 11'b100_0000_0000); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 1'($urandom_range(0, 1));
      b         = 1'($urandom_range(0, 1));
      s         = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) == 0);
      clear     = ($urandom_range(0, 15) == 0);
      rst_n     = ($urandom_range(0, 63) != 0);
      step();
      total++; if (obs1 !== exp_vec(1)) $display("FAIL random_dup1 cyc=%0d got=%b exp=%b", i, obs1, exp_vec(1)); else passed++;
      total++; if (obs0 !== exp_vec(0)) $display("FAIL random_dup0 cyc=%0d got=%b exp=%b", i, obs0, exp_vec(0)); else passed++;
    end
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; s = 1'b0; out_ready = 1'b0;
    model_clear(0);
    model_clear(1);
    test_reset();
    test_in_order();
    test_out_of_order_hold();
    test_dup_allowed();
    test_dup_rejected();
    test_clear_wins();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
